// File: rtl/req_tx_framer.sv
// req_tx_framer: pops 64-bit request words from a first-word-fall-through FIFO and wraps them
// in delimited frames (START control word, 1..MAX_BURST data words, END control word). Words
// leave through a registered valid/ready output toward the PHY TX encoder. A frame closes when
// the burst limit is reached or when the FIFO has stayed empty for HOLD cycles.
//
// Ports:
//   clk        - clock
//   reset      - asynchronous, active-high reset
//   fifo_empty - FIFO empty flag
//   fifo_data  - FIFO head word, valid while fifo_empty=0
//   fifo_rd    - pop strobe (combinational)
//   tx_ready   - PHY accepts the presented word this cycle
//   tx_valid   - tx_data/tx_ctrl valid (registered)
//   tx_data    - output word (registered)
//   tx_ctrl    - 1 = control word (START/END), 0 = data word
//   busy       - high while a frame is open (DATA or END_WAIT)
//   frame_cnt  - number of END words accepted by the PHY, wraps
module req_tx_framer #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned HOLD      = 2,
  parameter logic [7:0]  DELIM     = 8'hee
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_ctrl,
  output logic             busy,
  output logic [15:0]      frame_cnt
);

  localparam logic [7:0] TypeStart = 8'hfb;
  localparam logic [7:0] TypeEnd   = 8'hfd;
  localparam logic [7:0] MaxBurst  = 8'(MAX_BURST);
  localparam int unsigned GapW     = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
  localparam logic [GapW-1:0] Hold = GapW'(HOLD);

  typedef enum logic [1:0] {StIdle, StData, StEndWait} state_e;

  state_e           state_q, state_d;
  logic [7:0]       burst_q, burst_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [15:0]      seq_q, seq_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             tx_valid_q, tx_valid_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             tx_ctrl_q, tx_ctrl_d;
  logic             free;
  logic             end_accept;

  function automatic logic [63:0] ctrl_word(input logic [7:0] kind, input logic [15:0] seq,
                                            input logic [7:0] cnt);
    return {DELIM, kind, seq, 24'h0, cnt};
  endfunction

  always_comb begin
    free        = ~tx_valid_q | tx_ready;
    end_accept  = tx_valid_q & tx_ready & tx_ctrl_q & (tx_data_q[55:48] == TypeEnd);

    state_d     = state_q;
    burst_d     = burst_q;
    gap_d       = gap_q;
    seq_d       = seq_q;
    frame_cnt_d = frame_cnt_q;
    fifo_rd     = 1'b0;
    // A stalled word stays valid; a free register with nothing loaded goes invalid.
    tx_valid_d  = tx_valid_q & ~tx_ready;
    tx_data_d   = tx_data_q;
    tx_ctrl_d   = tx_ctrl_q;

    case (state_q)
      StIdle: begin
        if (!fifo_empty && free) begin
          tx_valid_d = 1'b1;
          tx_data_d  = WIDTH'(ctrl_word(TypeStart, seq_q, 8'd0));
          tx_ctrl_d  = 1'b1;
          burst_d    = 8'd0;
          gap_d      = '0;
          state_d    = StData;
        end
      end
      StData: begin
        // Gap counts every empty cycle, even while the output is stalled.
        if (fifo_empty && (gap_q != Hold)) begin
          gap_d = gap_q + 1'b1;
        end
        if (!fifo_empty && (burst_q < MaxBurst)) begin
          // A word arriving exactly when gap reaches HOLD still joins this frame.
          if (free) begin
            tx_valid_d = 1'b1;
            tx_data_d  = fifo_data;
            tx_ctrl_d  = 1'b0;
            fifo_rd    = 1'b1;
            burst_d    = burst_q + 8'd1;
            gap_d      = '0;
          end
        end else if (((burst_q == MaxBurst) || (fifo_empty && (gap_q == Hold))) && free) begin
          tx_valid_d = 1'b1;
          tx_data_d  = WIDTH'(ctrl_word(TypeEnd, seq_q, burst_q));
          tx_ctrl_d  = 1'b1;
          seq_d      = seq_q + 16'd1;
          state_d    = StEndWait;
        end
      end
      StEndWait: begin
        if (end_accept) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      burst_q     <= 8'd0;
      gap_q       <= '0;
      seq_q       <= 16'd0;
      frame_cnt_q <= 16'd0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_ctrl_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      gap_q       <= gap_d;
      seq_q       <= seq_d;
      frame_cnt_q <= frame_cnt_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      tx_ctrl_q   <= tx_ctrl_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign tx_ctrl   = tx_ctrl_q;
  assign busy      = (state_q == StData) || (state_q == StEndWait);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_req_tx_framer.sv
// Testbench for req_tx_framer: a queue models the FWFT FIFO, every word accepted by the PHY is
// logged, and the log is compared against frames built from the framing rules.
module tb_req_tx_framer;
  localparam int unsigned MaxBurst = 4;
  localparam int unsigned Hold     = 2;
  localparam logic [7:0]  Delim    = 8'hee;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_empty;
  logic [63:0] fifo_data;
  logic        fifo_rd;
  logic        tx_ready;
  logic        tx_valid;
  logic [63:0] tx_data;
  logic        tx_ctrl;
  logic        busy;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  req_tx_framer #(
    .WIDTH    (64),
    .MAX_BURST(MaxBurst),
    .HOLD     (Hold),
    .DELIM    (Delim)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ctrl   (tx_ctrl),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic        pend_pop = 1'b0;
  logic [63:0] fq[$];
  logic [64:0] acc_q[$];
  int          acc_cyc[$];
  logic [64:0] exp_q[$];
  logic [15:0] m_seq = 16'd0;
  logic [15:0] m_frames = 16'd0;

  function automatic logic [64:0] ctl_word(input logic is_end, input logic [15:0] s,
                                           input logic [7:0] n);
    logic [7:0] kind;
    kind = is_end ? 8'hfd : 8'hfb;
    return {1'b1, Delim, kind, s, 24'h0, n};
  endfunction

  // Reference: words all available up front split into chunks of MaxBurst, one frame per chunk.
  function automatic void model_words(input logic [63:0] w[$]);
    int i;
    int n;
    i = 0;
    while (i < w.size()) begin
      n = w.size() - i;
      if (n > int'(MaxBurst)) n = int'(MaxBurst);
      exp_q.push_back(ctl_word(1'b0, m_seq, 8'd0));
      for (int k = 0; k < n; k++) exp_q.push_back({1'b0, w[i+k]});
      exp_q.push_back(ctl_word(1'b1, m_seq, 8'(n)));
      m_seq    = m_seq + 16'd1;
      m_frames = m_frames + 16'd1;
      i += n;
    end
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() == 0) ? 64'h0bad_0bad_0bad_0bad : fq[0];
  endtask

  // One clock: sample handshakes mid-cycle, then apply the pop after the edge.
  task automatic step();
    drive_fifo();
    #1;
    pend_pop = fifo_rd;
    if (tx_valid && tx_ready) begin
      acc_q.push_back({tx_ctrl, tx_data});
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (pend_pop && fq.size() > 0) fq.delete(0);
    cyc++;
    drive_fifo();
  endtask

  task automatic drain(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (!busy && !tx_valid && fq.size() == 0 && !fifo_rd) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic clear_logs();
    acc_q.delete();
    acc_cyc.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    tx_ready = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", tx_valid); end
    n_cmp++;
    if (tx_data !== 64'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", tx_data); end
    n_cmp++;
    if (tx_ctrl !== 1'b0) begin n_err++; $display("FAIL rst_ctrl: got %b want 0", tx_ctrl); end
    n_cmp++;
    if (fifo_rd !== 1'b0) begin n_err++; $display("FAIL rst_rd: got %b want 0", fifo_rd); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++;
    if (frame_cnt !== 16'h0) begin n_err++; $display("FAIL rst_fcnt: got %h want 0", frame_cnt); end
    reset    = 1'b0;
    tx_ready = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL idle_empty: got valid=%b busy=%b want 0/0", tx_valid, busy);
    end
  endtask

  task automatic test_single_frame();
    logic [63:0] w[$];
    int p;
    bit to;
    clear_logs();
    tx_ready = 1'b1;
    w = '{64'hA, 64'hB, 64'hC};
    model_words(w);
    p = cyc;
    foreach (w[i]) fq.push_back(w[i]);
    drain(60, to);
    n_cmp++;
    if (to) begin n_err++; $display("FAIL single_drain: got timeout want idle"); end
    n_cmp++;
    if (acc_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL single_len: got %0d want %0d", acc_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (acc_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL single_word%0d: got %h want %h", i, acc_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (acc_cyc[0] != p + 1) begin
        n_err++; $display("FAIL single_start_lat: got %0d want %0d", acc_cyc[0], p + 1);
      end
      n_cmp++;
      if (acc_cyc[1] != p + 2 || acc_cyc[2] != p + 3 || acc_cyc[3] != p + 4) begin
        n_err++; $display("FAIL single_stream: got %0d,%0d,%0d want %0d,%0d,%0d",
                          acc_cyc[1], acc_cyc[2], acc_cyc[3], p + 2, p + 3, p + 4);
      end
      n_cmp++;
      if (acc_cyc[4] != acc_cyc[3] + int'(Hold) + 1) begin
        n_err++; $display("FAIL single_end_hold: got %0d want %0d", acc_cyc[4],
                          acc_cyc[3] + int'(Hold) + 1);
      end
    end
    n_cmp++;
    if (frame_cnt !== m_frames) begin
      n_err++; $display("FAIL single_fcnt: got %h want %h", frame_cnt, m_frames);
    end
  endtask

  task automatic test_burst_split();
    logic [63:0] w[$];
    bit to;
    clear_logs();
    tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) w.push_back(rnd64());
    model_words(w);
    foreach (w[i]) fq.push_back(w[i]);
    drain(80, to);
    n_cmp++;
    if (to) begin n_err++; $display("FAIL burst_drain: got timeout want idle"); end
    n_cmp++;
    if (acc_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL burst_len: got %0d want %0d", acc_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (acc_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL burst_word%0d: got %h want %h", i, acc_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (acc_cyc[5] != acc_cyc[4] + 1) begin
        n_err++; $display("FAIL burst_end_lat: got %0d want %0d", acc_cyc[5], acc_cyc[4] + 1);
      end
      n_cmp++;
      if (acc_cyc[6] < acc_cyc[5] + 2) begin
        n_err++; $display("FAIL burst_restart: got %0d want >=%0d", acc_cyc[6], acc_cyc[5] + 2);
      end
    end
    n_cmp++;
    if (frame_cnt !== m_frames) begin
      n_err++; $display("FAIL burst_fcnt: got %h want %h", frame_cnt, m_frames);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] w[$];
    logic [63:0] held;
    bit found;
    bit to;
    clear_logs();
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) w.push_back(rnd64());
    model_words(w);
    foreach (w[i]) fq.push_back(w[i]);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_valid && !tx_ctrl) begin found = 1'b1; break; end
    end
    n_cmp++;
    if (!found) begin
      n_err++; $display("FAIL bp_first_data: got none want data word");
    end else begin
      held     = tx_data;
      tx_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
        step();
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_ctrl !== 1'b0 || tx_data !== held || fifo_rd !== 1'b0) begin
          n_err++; $display("FAIL bp_hold%0d: got v=%b c=%b d=%h rd=%b want 1/0/%h/0", k,
                            tx_valid, tx_ctrl, tx_data, fifo_rd, held);
        end
      end
      tx_ready = 1'b1;
    end
    drain(60, to);
    n_cmp++;
    if (to) begin n_err++; $display("FAIL bp_drain: got timeout want idle"); end
    n_cmp++;
    if (acc_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL bp_len: got %0d want %0d", acc_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (acc_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL bp_word%0d: got %h want %h", i, acc_q[i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if (frame_cnt !== m_frames) begin
      n_err++; $display("FAIL bp_fcnt: got %h want %h", frame_cnt, m_frames);
    end
  endtask

  // Second word arrives after e empty cycles; it joins the frame only while e <= Hold.
  task automatic test_late_arrival();
    logic [63:0] w0, w1;
    logic [63:0] q[$];
    bit emptied;
    bit to;
    for (int e = 1; e <= int'(Hold) + 1; e++) begin
      clear_logs();
      tx_ready = 1'b1;
      w0 = rnd64();
      w1 = rnd64();
      fq.push_back(w0);
      emptied = 1'b0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (fq.size() == 0) begin emptied = 1'b1; break; end
      end
      n_cmp++;
      if (!emptied) begin n_err++; $display("FAIL late%0d_pop: got no pop want pop", e); end
      repeat (e) step();
      fq.push_back(w1);
      q.delete();
      if (e <= int'(Hold)) begin
        q.push_back(w0);
        q.push_back(w1);
        model_words(q);
      end else begin
        q.push_back(w0);
        model_words(q);
        q.delete();
        q.push_back(w1);
        model_words(q);
      end
      drain(60, to);
      n_cmp++;
      if (to) begin n_err++; $display("FAIL late%0d_drain: got timeout want idle", e); end
      n_cmp++;
      if (acc_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL late%0d_len: got %0d want %0d", e, acc_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          n_cmp++;
          if (acc_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL late%0d_word%0d: got %h want %h", e, i, acc_q[i], exp_q[i]);
          end
        end
      end
      n_cmp++;
      if (frame_cnt !== m_frames) begin
        n_err++; $display("FAIL late%0d_fcnt: got %h want %h", e, frame_cnt, m_frames);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] w[$];
    logic [64:0] held;
    bit stall;
    bit to;
    for (int r = 0; r < 4; r++) begin
      clear_logs();
      w.delete();
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) w.push_back(rnd64());
      model_words(w);
      foreach (w[i]) fq.push_back(w[i]);
      to = 1'b1;
      for (int c = 0; c < 400; c++) begin
        tx_ready = ($urandom_range(0, 3) != 0);
        stall    = tx_valid && !tx_ready;
        held     = {tx_ctrl, tx_data};
        step();
        if (stall) begin
          n_cmp++;
          if (pend_pop !== 1'b0 || tx_valid !== 1'b1 || {tx_ctrl, tx_data} !== held) begin
            n_err++; $display("FAIL rnd%0d_stall: got rd=%b v=%b w=%h want 0/1/%h", r, pend_pop,
                              tx_valid, {tx_ctrl, tx_data}, held);
          end
        end
        if (!busy && !tx_valid && fq.size() == 0 && !fifo_rd) begin to = 1'b0; break; end
      end
      tx_ready = 1'b1;
      n_cmp++;
      if (to) begin n_err++; $display("FAIL rnd%0d_drain: got timeout want idle", r); end
      n_cmp++;
      if (acc_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL rnd%0d_len: got %0d want %0d", r, acc_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          n_cmp++;
          if (acc_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL rnd%0d_word%0d: got %h want %h", r, i, acc_q[i], exp_q[i]);
          end
        end
      end
      n_cmp++;
      if (frame_cnt !== m_frames) begin
        n_err++; $display("FAIL rnd%0d_fcnt: got %h want %h", r, frame_cnt, m_frames);
      end
    end
  endtask

  // Preload seq and frame_cnt just below the wrap instead of running 65536 frames.
  task automatic test_seq_wrap();
    logic [63:0] w[$];
    bit to;
    clear_logs();
    tx_ready = 1'b1;
    force dut.seq_q = 16'hffff;
    force dut.frame_cnt_q = 16'hffff;
    step();
    step();
    release dut.seq_q;
    release dut.frame_cnt_q;
    m_seq    = 16'hffff;
    m_frames = 16'hffff;
    for (int i = 0; i < int'(MaxBurst) + 1; i++) w.push_back(rnd64());
    model_words(w);
    foreach (w[i]) fq.push_back(w[i]);
    drain(80, to);
    n_cmp++;
    if (to) begin n_err++; $display("FAIL wrap_drain: got timeout want idle"); end
    n_cmp++;
    if (acc_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL wrap_len: got %0d want %0d", acc_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (acc_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL wrap_word%0d: got %h want %h", i, acc_q[i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if (frame_cnt !== m_frames) begin
      n_err++; $display("FAIL wrap_fcnt: got %h want %h", frame_cnt, m_frames);
    end
  endtask

  task automatic test_reset_midstream();
    logic [63:0] w[$];
    bit to;
    clear_logs();
    tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) fq.push_back(rnd64());
    repeat (3) step();
    reset = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", tx_valid); end
    n_cmp++;
    if (fifo_rd !== 1'b0) begin n_err++; $display("FAIL mid_rst_rd: got %b want 0", fifo_rd); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_cmp++;
    if (frame_cnt !== 16'h0) begin
      n_err++; $display("FAIL mid_rst_fcnt: got %h want 0", frame_cnt);
    end
    // Popped words are gone; whatever is still in the FIFO forms the next frames from seq 0.
    clear_logs();
    m_seq    = 16'd0;
    m_frames = 16'd0;
    w = fq;
    model_words(w);
    reset = 1'b0;
    drain(80, to);
    n_cmp++;
    if (to) begin n_err++; $display("FAIL mid_drain: got timeout want idle"); end
    n_cmp++;
    if (acc_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL mid_len: got %0d want %0d", acc_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (acc_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL mid_word%0d: got %h want %h", i, acc_q[i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if (frame_cnt !== m_frames) begin
      n_err++; $display("FAIL mid_fcnt: got %h want %h", frame_cnt, m_frames);
    end
  endtask

  initial begin
    reset    = 1'b1;
    tx_ready = 1'b0;
    drive_fifo();
    @(posedge clk);
    #1;
    test_reset();
    test_single_frame();
    test_burst_split();
    test_backpressure();
    test_late_arrival();
    test_random();
    test_seq_wrap();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
